// File: rtl/sweep_trigger_gen_pkg.sv
// Shared definitions for the A-line trigger sequencer: register map, bit positions,
// sequencer state encoding and a small helper for "zero means one" fields.
package sweep_trigger_gen_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_LINES   = 3'd2;
    localparam logic [2:0] REG_WIDTH   = 3'd3;
    localparam logic [2:0] REG_DELAY   = 3'd4;
    localparam logic [2:0] REG_LCOUNT  = 3'd5;

    localparam int STAT_RUNNING    = 0;
    localparam int STAT_FRAME_DONE = 1;
    localparam int STAT_OVERRUN    = 2;

    localparam int CTRL_IRQ_EN     = 0;
    localparam int CTRL_CONTINUOUS = 1;
    localparam int CTRL_START      = 2;
    localparam int CTRL_STOP       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } trig_state_t;

    // Line count and pulse width of zero are treated as one.
    function automatic logic [15:0] at_least_one(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

endpackage

// File: rtl/sweep_trig_core.sv
// Trigger sequencer core: tick edge detect, IDLE/ARMED/DELAY/PULSE FSM, line counting
// and the per-frame shadow copies of the line/width/delay configuration.
module sweep_trig_core
    import sweep_trigger_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [15:0] lines_cfg,
    input  logic [15:0] width_cfg,
    input  logic [15:0] delay_cfg,
    output logic        trig_out,
    output logic        frame_active,
    output logic [15:0] line_cnt,
    output logic        frame_done_set,
    output logic        overrun_set
);

    trig_state_t state;
    logic        tick_q;
    logic        tick_edge;
    logic [15:0] cnt;
    logic [15:0] shadow_lines;
    logic [15:0] shadow_width;
    logic [15:0] shadow_delay;
    logic        last_line;

    assign tick_edge      = tick_in & ~tick_q;
    assign last_line      = (line_cnt == at_least_one(shadow_lines) - 16'd1);
    assign frame_active   = (state != ST_IDLE);
    assign overrun_set    = tick_edge && ((state == ST_DELAY) || (state == ST_PULSE));
    assign frame_done_set = !stop && (state == ST_PULSE) && (cnt == 16'd0) && last_line;

    // Stop has priority over every transition; trig_out mirrors the PULSE state one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            tick_q       <= 1'b0;
            cnt          <= 16'd0;
            line_cnt     <= 16'd0;
            shadow_lines <= 16'd0;
            shadow_width <= 16'd0;
            shadow_delay <= 16'd0;
            trig_out     <= 1'b0;
        end else begin
            tick_q   <= tick_in;
            trig_out <= (state == ST_PULSE) && !stop;
            if (stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state        <= ST_ARMED;
                            line_cnt     <= 16'd0;
                            shadow_lines <= lines_cfg;
                            shadow_width <= width_cfg;
                            shadow_delay <= delay_cfg;
                        end
                    end
                    ST_ARMED: begin
                        if (tick_edge) begin
                            if (shadow_delay != 16'd0) begin
                                state <= ST_DELAY;
                                cnt   <= shadow_delay - 16'd1;
                            end else begin
                                state <= ST_PULSE;
                                cnt   <= at_least_one(shadow_width) - 16'd1;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (cnt == 16'd0) begin
                            state <= ST_PULSE;
                            cnt   <= at_least_one(shadow_width) - 16'd1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt != 16'd0) begin
                            cnt <= cnt - 16'd1;
                        end else if (last_line) begin
                            if (continuous) begin
                                state        <= ST_ARMED;
                                line_cnt     <= 16'd0;
                                shadow_lines <= lines_cfg;
                                shadow_width <= width_cfg;
                                shadow_delay <= delay_cfg;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            state    <= ST_ARMED;
                            line_cnt <= line_cnt + 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/sweep_trigger_gen.sv
// A-line trigger sequencer top: Avalon-MM register file, sticky status bits, irq and
// the registered read mux around the sweep_trig_core sequencer.
module sweep_trigger_gen
    import sweep_trigger_gen_pkg::*;
#(
    parameter int LINES_DEFAULT = 1024,
    parameter int WIDTH_DEFAULT = 20,
    parameter int DELAY_DEFAULT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        tick_in,
    output logic        trig_out,
    output logic        frame_active
);

    logic        wr_en;
    logic        start;
    logic        stop;
    logic        irq_en;
    logic        continuous;
    logic [15:0] lines_reg;
    logic [15:0] width_reg;
    logic [15:0] delay_reg;
    logic        frame_done;
    logic        overrun;
    logic [15:0] line_cnt;
    logic        frame_done_set;
    logic        overrun_set;
    logic [15:0] rd_mux;

    assign wr_en = chipselect && !write_n;
    assign start = wr_en && (address == REG_CONTROL) && writedata[CTRL_START];
    assign stop  = wr_en && (address == REG_CONTROL) && writedata[CTRL_STOP];
    assign irq   = frame_done && irq_en;

    sweep_trig_core u_core (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick_in        (tick_in),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .lines_cfg      (lines_reg),
        .width_cfg      (width_reg),
        .delay_cfg      (delay_reg),
        .trig_out       (trig_out),
        .frame_active   (frame_active),
        .line_cnt       (line_cnt),
        .frame_done_set (frame_done_set),
        .overrun_set    (overrun_set)
    );

    // Sticky bits: a set from the sequencer beats a clearing STATUS write in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en     <= 1'b0;
            continuous <= 1'b0;
            lines_reg  <= 16'(LINES_DEFAULT);
            width_reg  <= 16'(WIDTH_DEFAULT);
            delay_reg  <= 16'(DELAY_DEFAULT);
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            readdata   <= 16'd0;
        end else begin
            readdata <= rd_mux;
            if (wr_en) begin
                case (address)
                    REG_CONTROL: begin
                        irq_en     <= writedata[CTRL_IRQ_EN];
                        continuous <= writedata[CTRL_CONTINUOUS];
                    end
                    REG_LINES: lines_reg <= writedata;
                    REG_WIDTH: width_reg <= writedata;
                    REG_DELAY: delay_reg <= writedata;
                    default: ;
                endcase
            end
            if (frame_done_set) begin
                frame_done <= 1'b1;
            end else if (wr_en && (address == REG_STATUS)) begin
                frame_done <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (wr_en && (address == REG_STATUS)) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            REG_STATUS: begin
                rd_mux[STAT_RUNNING]    = frame_active;
                rd_mux[STAT_FRAME_DONE] = frame_done;
                rd_mux[STAT_OVERRUN]    = overrun;
            end
            REG_CONTROL: begin
                rd_mux[CTRL_IRQ_EN]     = irq_en;
                rd_mux[CTRL_CONTINUOUS] = continuous;
            end
            REG_LINES:  rd_mux = lines_reg;
            REG_WIDTH:  rd_mux = width_reg;
            REG_DELAY:  rd_mux = delay_reg;
            REG_LCOUNT: rd_mux = line_cnt;
            default:    rd_mux = 16'd0;
        endcase
    end

endmodule
